// File: rtl/multi_pulse_gen.sv
// Multi-channel edge-to-pulse generator: per-channel edge detect -> PULSE_LEN-cycle pulse.
// Latency: LVL_SIG sampled at edge k gives PULSE_SIG/EDGE_ANY high after edge k+D (D = 1, or SYNC_STAGES with PULSE_GEN_SYNC_EN).
// No backpressure: free-running, every cycle accepted; optional build macro PULSE_GEN_SYNC_EN adds an input synchroniser.
module multi_pulse_gen #(
   parameter int NUM_CH      = 1,
   parameter int PULSE_LEN   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] LVL_SIG,
   input  logic [1:0]        MODE,
   output logic [NUM_CH-1:0] PULSE_SIG,
   output logic              EDGE_ANY
);

   localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_LEN - 1);

`ifdef PULSE_GEN_SYNC_EN
   // Levels may be asynchronous: a full synchroniser chain in front of the detector.
   localparam int D = SYNC_STAGES;
`else
   // Levels are already synchronous: one sampling flop. SYNC_STAGES has no effect
   // in this build; the expression only keeps the parameter referenced.
   localparam int D = SYNC_STAGES - SYNC_STAGES + 1;
`endif

   logic [NUM_CH-1:0] r_chain [D];
   logic [NUM_CH-1:0] r_s1;
   logic [CW-1:0]     r_cnt   [NUM_CH];
   logic [NUM_CH-1:0] r_pulse;
   logic              r_edge_any;

   logic [NUM_CH-1:0] w_s0;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] w_det;

   assign w_s0   = r_chain[D-1];
   assign w_rise = w_s0 & ~r_s1;
   assign w_fall = ~w_s0 & r_s1;

   // Input sampling / synchroniser chain, plus the one-cycle-delayed copy of its last flop.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < D; i++) begin
            r_chain[i] <= '0;
         end
         r_s1 <= '0;
      end else begin
         r_chain[0] <= LVL_SIG;
         for (int i = 1; i < D; i++) begin
            r_chain[i] <= r_chain[i-1];
         end
         r_s1 <= w_s0;
      end
   end

   // Edge select shared by all channels; MODE 11 masks detection but not running pulses.
   always_comb begin
      w_det = '0;
      case (MODE)
         2'b00:   w_det = w_rise;
         2'b01:   w_det = w_fall;
         2'b10:   w_det = w_rise | w_fall;
         default: w_det = '0;
      endcase
   end

   // Per-channel pulse stretcher: a detection (re)loads the counter, so a retrigger
   // extends the pulse to PULSE_LEN cycles from the newest edge with no gap.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_cnt[c] <= '0;
         end
         r_pulse    <= '0;
         r_edge_any <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_det[c]) begin
               r_cnt[c]   <= LOAD_VAL;
               r_pulse[c] <= 1'b1;
            end else if (r_cnt[c] != '0) begin
               r_cnt[c]   <= r_cnt[c] - CW'(1);
               r_pulse[c] <= 1'b1;
            end else begin
               r_pulse[c] <= 1'b0;
            end
         end
         r_edge_any <= |w_det;
      end
   end

   assign PULSE_SIG = r_pulse;
   assign EDGE_ANY  = r_edge_any;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Bench for multi_pulse_gen: three instances (PULSE_LEN 1, 3, 5) share the same stimulus.
// Reference: pulse after edge n is high iff a detection occurred within the last PULSE_LEN edges.
// Detections are derived from the recorded per-edge input history and the pipeline depth D.
module tb_multi_pulse_gen;

   localparam int NCH  = 4;
   localparam int SS   = 3;
`ifdef PULSE_GEN_SYNC_EN
   localparam int D = SS;
`else
   localparam int D = 1;
`endif
   localparam int MAXN = 4096;

   logic       CLK  = 1'b0;
   logic       RST  = 1'b0;
   logic [3:0] LVL  = 4'h0;
   logic [1:0] MODE = 2'b00;

   logic [3:0] p1, p3, p5;
   logic       e1, e3, e5;

   int tests = 0;
   int fails = 0;

   // Reference history, indexed by edge number since the last reset release (1-based).
   logic [3:0] samp  [MAXN];
   logic [3:0] det_h [MAXN];
   int         n = 0;
   logic [3:0] ep1, ep3, ep5;
   logic       ee;

   always #5 CLK = ~CLK;

   multi_pulse_gen #(.NUM_CH(NCH), .PULSE_LEN(1), .SYNC_STAGES(SS)) u_l1 (
      .CLK(CLK), .RST(RST), .LVL_SIG(LVL), .MODE(MODE), .PULSE_SIG(p1), .EDGE_ANY(e1));
   multi_pulse_gen #(.NUM_CH(NCH), .PULSE_LEN(3), .SYNC_STAGES(SS)) u_l3 (
      .CLK(CLK), .RST(RST), .LVL_SIG(LVL), .MODE(MODE), .PULSE_SIG(p3), .EDGE_ANY(e3));
   multi_pulse_gen #(.NUM_CH(NCH), .PULSE_LEN(5), .SYNC_STAGES(SS)) u_l5 (
      .CLK(CLK), .RST(RST), .LVL_SIG(LVL), .MODE(MODE), .PULSE_SIG(p5), .EDGE_ANY(e5));

   function automatic logic [3:0] smp(int i);
      return (i < 1) ? 4'h0 : samp[i];
   endfunction

   function automatic logic [3:0] win(int len);
      logic [3:0] r;
      r = 4'h0;
      for (int m = n - len + 1; m <= n; m++)
         if (m >= 1) r = r | det_h[m];
      return r;
   endfunction

   // Advance one clock edge, record inputs, compute expectations, then settle 1 time unit.
   task automatic step();
      logic [3:0] s0, s1, d;
      @(posedge CLK);
      if (n >= MAXN - 1) begin
         $display("FAIL history_overflow n=%0d limit=%0d", n, MAXN - 1);
         $fatal(1);
      end
      n = n + 1;
      samp[n] = LVL;
      s0 = smp(n - D);
      s1 = smp(n - D - 1);
      case (MODE)
         2'b00:   d = s0 & ~s1;
         2'b01:   d = ~s0 & s1;
         2'b10:   d = (s0 & ~s1) | (~s0 & s1);
         default: d = 4'h0;
      endcase
      det_h[n] = d;
      ep1 = win(1);
      ep3 = win(3);
      ep5 = win(5);
      ee  = |d;
      #1;
   endtask

   task automatic test_reset();
      int first, cnt;
      LVL = 4'hF; MODE = 2'b00; RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== 15'h0) begin
            fails++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, {p1, p3, p5, e1, e3, e5});
         end
      end
      RST = 1'b1; n = 0;
      first = -1; cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL reset_release n=%0d got=%h exp=%h", n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
         if (p3 === 4'hF) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      tests++;
      if (first != D + 1 || cnt != 3) begin
         fails++;
         $display("FAIL reset_release_pulse first=%0d cnt=%0d exp_first=%0d exp_cnt=3", first, cnt, D + 1);
      end
   endtask

   task automatic test_edge_modes();
      int cr, cf, pos;
      int exp_r [3] = '{1, 0, 1};
      int exp_f [3] = '{0, 1, 1};
      LVL = 4'h0; MODE = 2'b00;
      for (int i = 0; i < 8; i++) step();
      for (int m = 0; m < 3; m++) begin
         MODE = 2'(m);
         cr = 0; cf = 0; pos = -1;
         LVL[0] = 1'b1;
         for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
               fails++;
               $display("FAIL edge_mode%0d_rise n=%0d got=%h exp=%h", m, n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
            end
            if (p1[0] === 1'b1) begin cr++; pos = i; end
         end
         LVL[0] = 1'b0;
         for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
               fails++;
               $display("FAIL edge_mode%0d_fall n=%0d got=%h exp=%h", m, n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
            end
            if (p1[0] === 1'b1) cf++;
         end
         tests++;
         if (cr != exp_r[m] || cf != exp_f[m] || (exp_r[m] == 1 && pos != D + 1)) begin
            fails++;
            $display("FAIL edge_mode%0d_count rise=%0d fall=%0d pos=%0d exp_rise=%0d exp_fall=%0d exp_pos=%0d",
                     m, cr, cf, pos, exp_r[m], exp_f[m], D + 1);
         end
      end
   endtask

   task automatic test_retrigger();
      int hi, rises, edges;
      logic prev;
      MODE = 2'b10; LVL = 4'h0;
      for (int i = 0; i < 8; i++) step();
      hi = 0; rises = 0; edges = 0; prev = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 1) LVL[0] = 1'b1;
         if (i == 4) LVL[0] = 1'b0;
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL retrigger n=%0d got=%h exp=%h", n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
         if (p5[0] === 1'b1) hi++;
         if (p5[0] === 1'b1 && !prev) rises++;
         prev = p5[0];
         if (e5 === 1'b1) edges++;
      end
      tests++;
      if (hi != 8 || rises != 1 || edges != 2) begin
         fails++;
         $display("FAIL retrigger_shape high=%0d starts=%0d edge_any=%0d exp 8/1/2", hi, rises, edges);
      end
   endtask

   task automatic test_back_to_back();
      int full;
      MODE = 2'b10;
      full = 0;
      for (int i = 1; i <= 12; i++) begin
         LVL = ~LVL;
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL back_to_back n=%0d got=%h exp=%h", n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
         if (i > D && p1 === 4'hF) full++;
      end
      tests++;
      if (full != 12 - D) begin
         fails++;
         $display("FAIL back_to_back_len1 full_cycles=%0d exp=%0d", full, 12 - D);
      end
      LVL = 4'h0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_disable_mid_pulse();
      int hi, later, guard;
      MODE = 2'b00; LVL = 4'h0;
      for (int i = 0; i < 8; i++) step();
      LVL[0] = 1'b1;
      hi = 0; guard = 0;
      while (p5[0] !== 1'b1 && guard < 10) begin
         step();
         guard++;
      end
      tests++;
      if (p5[0] !== 1'b1) begin
         fails++;
         $display("FAIL disable_start got=%b exp=1 within 10 cycles", p5[0]);
      end
      hi = 1;
      MODE = 2'b11;
      for (int i = 0; i < 8; i++) begin
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL disable_run n=%0d got=%h exp=%h", n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
         if (p5[0] === 1'b1) hi++;
      end
      later = 0;
      LVL[0] = 1'b0;
      for (int i = 0; i < 4; i++) step();
      LVL = 4'hF;
      for (int i = 0; i < 8; i++) begin
         step();
         if ({p1, p3, p5, e5} !== 13'h0) later++;
      end
      tests++;
      if (hi != 5 || later != 0) begin
         fails++;
         $display("FAIL disable_mid_pulse high=%0d later_active=%0d exp 5/0", hi, later);
      end
      MODE = 2'b00; LVL = 4'h0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_async_reset();
      int guard, after;
      MODE = 2'b00; LVL = 4'h0;
      for (int i = 0; i < 6; i++) step();
      LVL[1] = 1'b1;
      guard = 0;
      while (p5[1] !== 1'b1 && guard < 10) begin
         step();
         guard++;
      end
      step(); step();
      tests++;
      if (p5[1] !== 1'b1) begin
         fails++;
         $display("FAIL async_pre got=%b exp=1", p5[1]);
      end
      RST = 1'b0;
      #1;
      tests++;
      if ({p1, p3, p5, e1, e3, e5} !== 15'h0) begin
         fails++;
         $display("FAIL async_reset_immediate got=%h exp=0", {p1, p3, p5, e1, e3, e5});
      end
      LVL = 4'h0;
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b1; n = 0;
      after = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL async_release n=%0d got=%h exp=%h", n, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
         if (p5 !== 4'h0) after++;
      end
      tests++;
      if (after != 0) begin
         fails++;
         $display("FAIL async_no_resume active_cycles=%0d exp=0", after);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         LVL = 4'($urandom);
         if (i % 16 == 0) MODE = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0 && i % 16 != 0) LVL = samp[n];
         step();
         tests++;
         if ({p1, p3, p5, e1, e3, e5} !== {ep1, ep3, ep5, ee, ee, ee}) begin
            fails++;
            $display("FAIL random n=%0d mode=%b got=%h exp=%h", n, MODE, {p1, p3, p5, e1, e3, e5}, {ep1, ep3, ep5, ee, ee, ee});
         end
      end
   endtask

   initial begin
      test_reset();
      test_edge_modes();
      test_retrigger();
      test_back_to_back();
      test_disable_mid_pulse();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
